reg_elastic: RTL
================

REG_ELASTIC -- requirements
Module: reg_elastic

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the data word width in bits (width >= 1).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port FLUSH, input, 1 bit, synchronous clear of all stored words.
REQ-005 The block SHALL have port InValid, input, 1 bit, upstream word on D is offered.
REQ-006 The block SHALL have port InReady, output, 1 bit, block accepts a word this cycle.
REQ-007 The block SHALL have port D, input, width bits, upstream data word.
REQ-008 The block SHALL have port OutValid, output, 1 bit, word on Q is offered downstream.
REQ-009 The block SHALL have port OutReady, input, 1 bit, downstream accepts the word on Q.
REQ-010 The block SHALL have port Q, output, width bits, downstream data word.
REQ-011 The block SHALL have port Level, output, 2 bits, number of stored words (0..2).

Function
REQ-012 The block SHALL be a two-entry elastic pipeline register: main register M drives Q, skid register S absorbs one word when downstream stalls.
REQ-013 The block SHALL treat a transfer as in_fire = InValid & InReady and out_fire = OutValid & OutReady, evaluated at the rising clock edge.
REQ-014 The block SHALL implement states EMPTY (Level 0), ONE (Level 1, M valid), FULL (Level 2, M and S valid).
REQ-015 The block SHALL drive InReady = 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only (no combinational path from OutReady or InValid).
REQ-016 The block SHALL drive OutValid = 1 in ONE and FULL, 0 in EMPTY, decoded from registered state only.
REQ-017 The block SHALL drive Q = M at all times; Q value in EMPTY is the last M content and is don't-care.
REQ-018 EMPTY transitions: in_fire -> ONE with M <= D; otherwise stay.
REQ-019 ONE transitions: in_fire & out_fire -> ONE with M <= D; in_fire & !out_fire -> FULL with S <= D, M held; !in_fire & out_fire -> EMPTY; neither -> stay.
REQ-020 FULL transitions: out_fire -> ONE with M <= S; otherwise stay with M and S held (in_fire impossible since InReady = 0).
REQ-021 The block SHALL preserve word order exactly: words leave on Q in acceptance order, none lost, none duplicated.
REQ-022 The block SHALL sustain one word per cycle throughput with latency of exactly one cycle from in_fire to OutValid when entering from EMPTY.
REQ-023 FLUSH = 1 at a rising edge SHALL force state EMPTY, overriding any simultaneous in_fire or out_fire; the word offered on D in that cycle is discarded.
REQ-024 Held words SHALL remain stable on Q while OutValid = 1 and OutReady = 0.
REQ-025 Level SHALL equal 0, 1, 2 in EMPTY, ONE, FULL respectively; encoding 3 SHALL never occur.

Reset
REQ-026 While RST = 1 the block SHALL immediately, independent of CLK, enter EMPTY and clear M and S to all zeros.
REQ-027 Reset outputs: InReady = 1, OutValid = 0, Q = 0, Level = 0.
REQ-028 Deasserting RST mid-transfer SHALL discard all previously stored words; first edge after release behaves as EMPTY.

Verification
REQ-029 Reset: assert RST asynchronously between edges with Level = 2 -> Level 0, OutValid 0, InReady 1, Q 0 before the next edge.
REQ-030 Streaming: OutReady held 1, InValid 1 with D = 0x01..0x10 on consecutive cycles -> Q = 0x01..0x10 one cycle later, Level stays 1, InReady never drops.
REQ-031 Stall: accept 0xA5 then 0x5A with OutReady 0 -> Level 2, InReady 0, Q holds 0xA5; raise OutReady -> Q 0xA5 then 0x5A, Level 1 then 0.
REQ-032 Simultaneous: in ONE with M = 0x33, InValid 1, D = 0x44, OutReady 1 -> next cycle Q = 0x44, Level 1.
REQ-033 Flush: in FULL, FLUSH 1 with OutReady 1 and InValid 1 -> next cycle Level 0, OutValid 0, InReady 1, no word delivered.
REQ-034 Random: random InValid/OutReady over 10000 cycles with scoreboard -> output sequence equals input sequence, Level never 3.

Source files
------------

// File: rtl/reg_elastic.sv
// reg_elastic -- two-entry elastic pipeline register (skid buffer).
//
// The main register M always drives Q. The skid register S catches the one
// word that can arrive in the same cycle the downstream stage stalls, so
// that InReady can be a plain registered signal. Neither InReady nor
// OutValid has a combinational path from InValid or OutReady.
//
// Ports:
//   CLK      in   clock; all state changes on its rising edge
//   RST      in   asynchronous active-high reset (clears M and S)
//   FLUSH    in   synchronous clear of all stored words; wins over transfers
//   InValid  in   upstream offers the word on D
//   InReady  out  a word can be accepted this cycle
//   D        in   upstream data word [width-1:0]
//   OutValid out  the word on Q is offered downstream
//   OutReady in   downstream accepts the word on Q
//   Q        out  downstream data word [width-1:0] (= M)
//   Level    out  number of stored words, 0..2

module reg_elastic #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             InValid,
    output logic             InReady,
    input  logic [width-1:0] D,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [width-1:0] Q,
    output logic [1:0]       Level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [width-1:0] m_reg;
    logic [width-1:0] s_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [1:0]       level_reg;

    logic in_fire;
    logic out_fire;

    assign in_fire  = InValid & in_ready_reg;
    assign out_fire = out_valid_reg & OutReady;

    // Outputs are registered alongside the state so that each one always
    // equals the decode of the state it accompanies.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= EMPTY;
            m_reg         <= '0;
            s_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            level_reg     <= 2'd0;
        end else if (FLUSH) begin
            // Discards stored words and whatever is offered on D this cycle.
            state_reg     <= EMPTY;
            m_reg         <= '0;
            s_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            level_reg     <= 2'd0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        m_reg         <= D;
                        state_reg     <= ONE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                        level_reg     <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // Pass-through: M is consumed and refilled together.
                        m_reg <= D;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new word behind M.
                        s_reg         <= D;
                        state_reg     <= FULL;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        level_reg     <= 2'd2;
                    end else if (out_fire) begin
                        state_reg     <= EMPTY;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                        level_reg     <= 2'd0;
                    end
                end
                FULL: begin
                    // in_fire cannot happen here since InReady is low.
                    if (out_fire) begin
                        m_reg         <= s_reg;
                        state_reg     <= ONE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                        level_reg     <= 2'd1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    level_reg     <= 2'd0;
                end
            endcase
        end
    end

    assign InReady  = in_ready_reg;
    assign OutValid = out_valid_reg;
    assign Q        = m_reg;
    assign Level    = level_reg;

endmodule
